// File: rtl/button_reader_if.sv
// button_reader_if: pin-side bundle for the push-button reader.
// The board/bench side uses master; the reader itself uses slave.
`default_nettype none

interface button_reader_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   i_button;
    logic                   o_level;
    logic                   o_press;
    logic                   o_release;
    logic [COUNT_WIDTH-1:0] o_count;

    modport master (
        output i_button,
        input  o_level,
        input  o_press,
        input  o_release,
        input  o_count
    );

    modport slave (
        input  i_button,
        output o_level,
        output o_press,
        output o_release,
        output o_count
    );
endinterface

`default_nettype wire

// File: rtl/button_reader.sv
// button_reader: two-flop synchronizer, per-transition debounce FSM,
// registered level, press/release pulses and a wrapping press counter.
`default_nettype none

module button_reader #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    button_reader_if.slave  bus
);
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    logic                   sync1_q, sync2_q;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= STABLE_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
        end else begin
            sync1_q   <= bus.i_button;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = count_q;

        case (state_q)
            STABLE_LOW: begin
                cnt_d = '0;
                if (sync2_q) begin
                    // A single-cycle qualification accepts on the first sighting.
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_HIGH;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        count_d = count_q + COUNT_WIDTH'(1);
                    end else begin
                        state_d = WAIT_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (!sync2_q) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    count_d = count_q + COUNT_WIDTH'(1);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = STABLE_LOW;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        state_d = WAIT_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_LOW: begin
                if (sync2_q) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = STABLE_LOW;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.o_level   = level_q;
    assign bus.o_press   = press_q;
    assign bus.o_release = release_q;
    assign bus.o_count   = count_q;
endmodule

`default_nettype wire

// File: tb/tb_button_reader.sv
// tb_button_reader: directed button stimulus with a pulse scoreboard
// checked by a monitor running beside the stimulus.
`timescale 1ns/1ps
`default_nettype none

module tb_button_reader;
    localparam int D  = 4;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_reader_if #(.COUNT_WIDTH(CW)) bus ();

    button_reader #(
        .DEBOUNCE_CYCLES(D),
        .COUNT_WIDTH    (CW)
    ) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .bus      (bus.slave)
    );

    // Edge counter and the reset value seen by the most recent edge.
    int   cyc      = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    typedef struct {
        logic          kind;   // 1 = press, 0 = release
        logic [CW-1:0] cnt;
        int            at;
    } evt_t;

    evt_t          q[$];
    int            checks    = 0;
    int            failures  = 0;
    logic [CW-1:0] exp_cnt   = '0;
    logic          exp_level = 1'b0;
    bit            done      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Called on a falling edge; an accepted change appears D+2 edges later.
    task automatic drive(input logic v, input int hold, input bit accept);
        evt_t e;
        bus.i_button = v;
        if (accept) begin
            if (v) exp_cnt = exp_cnt + 1'b1;
            e.kind = v;
            e.cnt  = exp_cnt;
            e.at   = cyc + D + 2;
            q.push_back(e);
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic do_reset(input int edges, input logic btn);
        evt_t e;
        rst_n        = 1'b0;
        bus.i_button = btn;
        exp_cnt      = '0;
        repeat (edges) @(negedge clk);
        rst_n = 1'b1;
        if (btn) begin
            exp_cnt = 1;
            e.kind  = 1'b1;
            e.cnt   = exp_cnt;
            e.at    = cyc + D + 2;
            q.push_back(e);
        end
    endtask

    initial begin
        fork
            begin : stimulus
                // Reset with the button held high.
                do_reset(3, 1'b1);
                repeat (12) @(negedge clk);
                drive(1'b0, 20, 1'b1);
                // Clean press and release.
                drive(1'b1, 20, 1'b1);
                drive(1'b0, 20, 1'b1);
                // Bounce, then settle high.
                drive(1'b1, 2, 1'b0);
                drive(1'b0, 2, 1'b0);
                drive(1'b1, 2, 1'b0);
                drive(1'b0, 2, 1'b0);
                drive(1'b1, 20, 1'b1);
                drive(1'b0, 20, 1'b1);
                // Three-cycle glitch rejected, four-cycle pulse accepted.
                drive(1'b1, 3, 1'b0);
                drive(1'b0, 12, 1'b0);
                chk("count_after_glitch", 32'(bus.o_count), 32'd3);
                drive(1'b1, 4, 1'b1);
                drive(1'b0, 20, 1'b1);
                chk("count_after_short_pulse", 32'(bus.o_count), 32'd4);
                // Counter wrap.
                do_reset(2, 1'b0);
                repeat (3) @(negedge clk);
                for (int i = 0; i < 257; i++) begin
                    drive(1'b1, 6, 1'b1);
                    drive(1'b0, 6, 1'b1);
                end
                repeat (4) @(negedge clk);
                chk("count_after_wrap", 32'(bus.o_count), 32'd1);
                // Reset two cycles into qualification.
                do_reset(2, 1'b0);
                repeat (3) @(negedge clk);
                for (int i = 0; i < 7; i++) begin
                    drive(1'b1, 8, 1'b1);
                    drive(1'b0, 8, 1'b1);
                end
                chk("count_before_mid_reset", 32'(bus.o_count), 32'd7);
                drive(1'b1, 4, 1'b0);
                do_reset(2, 1'b1);
                repeat (20) @(negedge clk);
                chk("count_after_mid_reset", 32'(bus.o_count), 32'd1);
                drive(1'b0, 20, 1'b1);
                done = 1'b1;
            end
            begin : monitor
                evt_t e;
                while (!done) begin
                    @(negedge clk);
                    if (cyc > 0) begin
                        if (!rst_seen) begin
                            exp_level = 1'b0;
                            chk("reset_level",   32'(bus.o_level),   32'd0);
                            chk("reset_press",   32'(bus.o_press),   32'd0);
                            chk("reset_release", 32'(bus.o_release), 32'd0);
                            chk("reset_count",   32'(bus.o_count),   32'd0);
                        end else begin
                            chk("press_release_exclusive",
                                32'(bus.o_press & bus.o_release), 32'd0);
                            if (bus.o_press || bus.o_release) begin
                                if (q.size() == 0) begin
                                    checks++;
                                    failures++;
                                    $display("FAIL unexpected_pulse: got press=%0b release=%0b expected none at cycle %0d",
                                             bus.o_press, bus.o_release, cyc);
                                end else begin
                                    e = q.pop_front();
                                    chk("pulse_kind",  32'(bus.o_press), 32'(e.kind));
                                    chk("pulse_count", 32'(bus.o_count), 32'(e.cnt));
                                    chk("pulse_cycle", 32'(cyc),         32'(e.at));
                                    exp_level = e.kind;
                                end
                            end
                            chk("level", 32'(bus.o_level), 32'(exp_level));
                        end
                    end
                end
            end
        join
        chk("pending_events", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
